pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, max cycles allowed in any active stage before error.
REQ-002 SHALL have parameter CNT_W, default 16, width of frame counter.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a frame sequence (level sampled each edge).
REQ-006 SHALL have port stop  input  1  request to halt continuous operation at next frame boundary.
REQ-007 SHALL have port continuous  input  1  1 = loop frames, 0 = single frame.
REQ-008 SHALL have port err_clr  input  1  leave ERROR state.
REQ-009 SHALL have ports cap_done, gs_done, flt_done  input  1 each  stage-complete pulses from camera/RWM_1 write, grayscaler, filter.
REQ-010 SHALL have ports cap_en, gs_en, flt_en  output  1 each  stage enables.
REQ-011 SHALL have ports rwm1_en, rwm1_rw, rwm2_en, rwm2_rw  output  1 each  memory enables and direction (rw 1 = write, 0 = read).
REQ-012 SHALL have ports busy  output  1, error  output  1, state  output  3, frame_cnt  output  CNT_W.

Function
REQ-013 SHALL implement states IDLE=0, CAPTURE=1, GRAY=2, FILTER=3, ERROR=4; all outputs registered, valid in the cycle after the edge that enters the state.
REQ-014 IDLE: all enables 0, busy 0; start=1 at an edge -> CAPTURE.
REQ-015 CAPTURE: cap_en=1, rwm1_en=1, rwm1_rw=1; cap_done=1 -> GRAY.
REQ-016 GRAY: rwm1_en=1, rwm1_rw=0, gs_en=1, rwm2_en=1, rwm2_rw=1; gs_done=1 -> FILTER.
REQ-017 FILTER: rwm2_en=1, rwm2_rw=0, flt_en=1; flt_done=1 -> frame_cnt+1, then CAPTURE if continuous=1 and stop_pending=0, else IDLE.
REQ-018 busy SHALL be 1 in CAPTURE, GRAY, FILTER; 0 in IDLE, ERROR.
REQ-019 stop SHALL set internal sticky stop_pending in any state except IDLE-without-start; cleared on entry to IDLE; current frame always completes.
REQ-020 start while busy or in ERROR SHALL be ignored.
REQ-021 done pulses not matching the current stage SHALL be ignored (no state or counter change).
REQ-022 Watchdog counter SHALL clear on every state change and increment each cycle in CAPTURE/GRAY/FILTER; reaching TIMEOUT-1 without matching done -> ERROR.
REQ-023 Matching done and watchdog expiry on the same edge: done wins, no error.
REQ-024 ERROR: all enables 0, error=1, frame_cnt held; err_clr=1 -> IDLE, error=0, stop_pending cleared.
REQ-025 frame_cnt SHALL wrap from all-ones to 0 without flag.
REQ-026 start and stop asserted together in IDLE: exactly one frame runs, then IDLE.
REQ-027 Unused state encodings SHALL go to IDLE next edge with all enables 0.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, all enables 0, rwm1_rw=0, rwm2_rw=0, busy=0, error=0, frame_cnt=0, watchdog=0, stop_pending=0, including mid-frame.
REQ-029 First state change after rst_n release SHALL require a start sampled on a rising edge with rst_n=1.

Verification
REQ-030 Single frame: continuous=0, start 1 cycle, cap_done@+5, gs_done@+10, flt_done@+8 -> state 1,2,3,0 in order, frame_cnt=1, busy low after flt_done edge.
REQ-031 Continuous with stop: continuous=1, start, stop pulsed during 3rd frame's GRAY -> frame 3 completes, IDLE, frame_cnt=3.
REQ-032 Timeout: TIMEOUT=16, start, no cap_done -> ERROR after 16 cycles in CAPTURE, error=1, enables 0; err_clr -> IDLE, error=0.
REQ-033 Race: gs_done on same edge watchdog expires -> FILTER entered, error stays 0; stray flt_done in CAPTURE -> ignored.
REQ-034 Reset mid-GRAY: rst_n low -> all outputs 0 without clock edge, frame_cnt=0; restart runs normally.
REQ-035 Wrap: CNT_W=2, four frames continuous -> frame_cnt 1,2,3,0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Frame sequencer for the capture -> grayscale -> filter pipeline.
// Steps the stage enables and the RWM direction strobes. Includes a per-stage watchdog and an ERROR trap.
module pipeline_sequencer #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic             err_clr,
    input  logic             cap_done,
    input  logic             gs_done,
    input  logic             flt_done,
    output logic             cap_en,
    output logic             gs_en,
    output logic             flt_en,
    output logic             rwm1_en,
    output logic             rwm1_rw,
    output logic             rwm2_en,
    output logic             rwm2_rw,
    output logic             busy,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_GRAY    = 3'd2,
        S_FILTER  = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t           cur_state, nxt_state;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] cnt_d;
    logic             stop_pending, stop_pending_d;
    logic             cap_en_d, gs_en_d, flt_en_d;
    logic             rwm1_en_d, rwm1_rw_d, rwm2_en_d, rwm2_rw_d;
    logic             busy_d, error_d;

    assign state = cur_state;

    always_comb begin
        nxt_state      = cur_state;
        cnt_d          = frame_cnt;
        wd_d           = wd_q;
        stop_pending_d = stop_pending;

        case (cur_state)
            S_IDLE: begin
                if (start) begin
                    nxt_state = S_CAPTURE;
                    if (stop) stop_pending_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (cap_done)             nxt_state = S_GRAY;
                else if (wd_q == WD_LAST) nxt_state = S_ERROR;
                else                      wd_d = wd_q + 1'b1;
            end
            S_GRAY: begin
                if (gs_done)              nxt_state = S_FILTER;
                else if (wd_q == WD_LAST) nxt_state = S_ERROR;
                else                      wd_d = wd_q + 1'b1;
            end
            S_FILTER: begin
                if (flt_done) begin
                    cnt_d     = frame_cnt + 1'b1;
                    // A stop arriving on the boundary edge itself also ends the loop.
                    nxt_state = (continuous && !stop_pending && !stop) ? S_CAPTURE : S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    nxt_state = S_ERROR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ERROR: begin
                if (err_clr) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase

        if (stop && cur_state != S_IDLE) stop_pending_d = 1'b1;
        if (nxt_state != cur_state)      wd_d = '0;
        if (nxt_state == S_IDLE && cur_state != S_IDLE) stop_pending_d = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        cap_en_d  = 1'b0;
        gs_en_d   = 1'b0;
        flt_en_d  = 1'b0;
        rwm1_en_d = 1'b0;
        rwm1_rw_d = 1'b0;
        rwm2_en_d = 1'b0;
        rwm2_rw_d = 1'b0;
        busy_d    = 1'b0;
        error_d   = 1'b0;
        case (nxt_state)
            S_CAPTURE: begin
                cap_en_d  = 1'b1;
                rwm1_en_d = 1'b1;
                rwm1_rw_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_GRAY: begin
                gs_en_d   = 1'b1;
                rwm1_en_d = 1'b1;
                rwm2_en_d = 1'b1;
                rwm2_rw_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_FILTER: begin
                flt_en_d  = 1'b1;
                rwm2_en_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_ERROR: error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= S_IDLE;
            wd_q         <= '0;
            frame_cnt    <= '0;
            stop_pending <= 1'b0;
            cap_en       <= 1'b0;
            gs_en        <= 1'b0;
            flt_en       <= 1'b0;
            rwm1_en      <= 1'b0;
            rwm1_rw      <= 1'b0;
            rwm2_en      <= 1'b0;
            rwm2_rw      <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            wd_q         <= wd_d;
            frame_cnt    <= cnt_d;
            stop_pending <= stop_pending_d;
            cap_en       <= cap_en_d;
            gs_en        <= gs_en_d;
            flt_en       <= flt_en_d;
            rwm1_en      <= rwm1_en_d;
            rwm1_rw      <= rwm1_rw_d;
            rwm2_en      <= rwm2_en_d;
            rwm2_rw      <= rwm2_rw_d;
            busy         <= busy_d;
            error        <= error_d;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a vector table for one frame.
// Hand-written sequences cover the loop/stop, watchdog, race, reset and wrap cases.
module tb_pipeline_sequencer;

    localparam logic [6:0] I_START = 7'b1000000;
    localparam logic [6:0] I_STOP  = 7'b0100000;
    localparam logic [6:0] I_CONT  = 7'b0010000;
    localparam logic [6:0] I_CLR   = 7'b0001000;
    localparam logic [6:0] I_CAP   = 7'b0000100;
    localparam logic [6:0] I_GS    = 7'b0000010;
    localparam logic [6:0] I_FLT   = 7'b0000001;
    localparam logic [6:0] I_NONE  = 7'b0000000;

    localparam logic [2:0] IDLE = 3'd0, CAP = 3'd1, GRAY = 3'd2, FILT = 3'd3, ERR = 3'd4;

    typedef struct {
        logic [6:0] in;
        logic [2:0] st;
        logic [1:0] cnt;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, stop = 1'b0, continuous = 1'b0, err_clr = 1'b0;
    logic       cap_done = 1'b0, gs_done = 1'b0, flt_done = 1'b0;
    logic       cap_en, gs_en, flt_en, rwm1_en, rwm1_rw, rwm2_en, rwm2_rw;
    logic       busy, error;
    logic [2:0] state;
    logic [1:0] frame_cnt;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_cnt = 2'd0;
    vec_t       vecs[$];

    pipeline_sequencer #(.TIMEOUT(16), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .continuous(continuous), .err_clr(err_clr),
        .cap_done(cap_done), .gs_done(gs_done), .flt_done(flt_done),
        .cap_en(cap_en), .gs_en(gs_en), .flt_en(flt_en),
        .rwm1_en(rwm1_en), .rwm1_rw(rwm1_rw), .rwm2_en(rwm2_en), .rwm2_rw(rwm2_rw),
        .busy(busy), .error(error), .state(state), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // {cap_en, gs_en, flt_en, rwm1_en, rwm1_rw, rwm2_en, rwm2_rw} per state
    function automatic logic [6:0] en_of(input logic [2:0] s);
        case (s)
            CAP:     return 7'b1001100;
            GRAY:    return 7'b0101011;
            FILT:    return 7'b0010010;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check(input string name, input logic [2:0] exp_st);
        cmp({name, ".state"}, 32'(state), 32'(exp_st));
        cmp({name, ".busy"}, 32'(busy), 32'(exp_st inside {CAP, GRAY, FILT}));
        cmp({name, ".error"}, 32'(error), 32'(exp_st == ERR));
        cmp({name, ".enables"},
            32'({cap_en, gs_en, flt_en, rwm1_en, rwm1_rw, rwm2_en, rwm2_rw}), 32'(en_of(exp_st)));
        cmp({name, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    endtask

    task automatic cycle(input logic [6:0] in, input logic [2:0] exp_st, input string name);
        {start, stop, continuous, err_clr, cap_done, gs_done, flt_done} = in;
        @(posedge clk);
        #1;
        check(name, exp_st);
    endtask

    task automatic run_frame(input logic cont, input logic stop_in_gray, input logic [2:0] after);
        logic [6:0] c;
        c = cont ? I_CONT : I_NONE;
        cycle(c | I_CAP, GRAY, "frame_cap");
        if (stop_in_gray) cycle(c | I_STOP, GRAY, "frame_stop");
        cycle(c | I_GS, FILT, "frame_gs");
        exp_cnt = exp_cnt + 2'd1;
        cycle(c | I_FLT, after, "frame_flt");
    endtask

    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 2'd0;
        check(name, IDLE);
        {start, stop, continuous, err_clr, cap_done, gs_done, flt_done} = I_START;
        @(posedge clk);
        #1;
        check({name, "_held"}, IDLE);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [6:0] in, input logic [2:0] st, input logic [1:0] cnt,
                       input string name, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) vecs.push_back('{in, st, cnt, name});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Single frame: cap_done @+5, gs_done @+10, flt_done @+8, stray pulses ignored.
        add(I_NONE,  IDLE, 0, "idle_no_start", 2);
        add(I_START, CAP,  0, "start", 1);
        add(I_NONE,  CAP,  0, "cap_wait", 1);
        add(I_FLT,   CAP,  0, "cap_stray_flt", 1);
        add(I_GS,    CAP,  0, "cap_stray_gs", 1);
        add(I_START, CAP,  0, "cap_start_busy", 1);
        add(I_CAP,   GRAY, 0, "cap_done", 1);
        add(I_NONE,  GRAY, 0, "gray_wait", 5);
        add(I_CAP,   GRAY, 0, "gray_stray_cap", 1);
        add(I_FLT,   GRAY, 0, "gray_stray_flt", 1);
        add(I_START, GRAY, 0, "gray_start_busy", 1);
        add(I_NONE,  GRAY, 0, "gray_wait2", 1);
        add(I_GS,    FILT, 0, "gs_done", 1);
        add(I_NONE,  FILT, 0, "filt_wait", 4);
        add(I_CAP,   FILT, 0, "filt_stray_cap", 1);
        add(I_GS,    FILT, 0, "filt_stray_gs", 1);
        add(I_NONE,  FILT, 0, "filt_wait2", 1);
        add(I_FLT,   IDLE, 1, "flt_done", 1);
        add(I_NONE,  IDLE, 1, "idle_after", 1);

        #2 rst_n = 1'b0;
        #1 check("reset", IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            exp_cnt = vecs[i].cnt;
            cycle(vecs[i].in, vecs[i].st, vecs[i].name);
        end

        // Continuous loop, stop pulsed in the third frame's GRAY.
        do_reset("rst_pre_cont");
        cycle(I_CONT | I_START, CAP, "cont_start");
        run_frame(1'b1, 1'b0, CAP);
        run_frame(1'b1, 1'b0, CAP);
        run_frame(1'b1, 1'b1, IDLE);
        cmp("cont_stop_cnt", 32'(frame_cnt), 32'd3);
        cycle(I_CONT, IDLE, "cont_idle_hold");

        // Stop in IDLE without start must not leave a pending stop.
        cycle(I_CONT | I_STOP, IDLE, "idle_stop_only");
        cycle(I_CONT | I_START, CAP, "cont_restart");
        run_frame(1'b1, 1'b0, CAP);
        run_frame(1'b1, 1'b1, IDLE);

        // Start and stop together in IDLE: exactly one frame.
        cycle(I_CONT | I_START | I_STOP, CAP, "start_stop_idle");
        run_frame(1'b1, 1'b0, IDLE);

        // Watchdog: 16 cycles in CAPTURE without cap_done.
        cycle(I_START, CAP, "to_start");
        for (int i = 0; i < 15; i++) cycle(I_NONE, CAP, "to_wait");
        cycle(I_NONE, ERR, "to_expire");
        cycle(I_START, ERR, "err_start_ignored");
        cycle(I_CAP | I_STOP, ERR, "err_done_ignored");
        cycle(I_CLR, IDLE, "err_clr");
        cycle(I_CONT | I_START, CAP, "post_err_start");
        run_frame(1'b1, 1'b0, CAP);
        run_frame(1'b1, 1'b1, IDLE);

        // gs_done on the expiry edge wins.
        cycle(I_START, CAP, "race_start");
        cycle(I_CAP, GRAY, "race_cap");
        for (int i = 0; i < 15; i++) cycle(I_NONE, GRAY, "race_wait");
        cycle(I_GS, FILT, "race_gs");
        exp_cnt = exp_cnt + 2'd1;
        cycle(I_FLT, IDLE, "race_flt");

        // Asynchronous reset mid-GRAY, then a normal frame.
        cycle(I_START, CAP, "mid_start");
        cycle(I_CAP, GRAY, "mid_cap");
        do_reset("rst_mid_gray");
        cycle(I_NONE, IDLE, "post_rst_no_start");
        cycle(I_START, CAP, "post_rst_start");
        run_frame(1'b0, 1'b0, IDLE);
        cmp("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // Two-bit counter wraps over four continuous frames.
        do_reset("rst_pre_wrap");
        cycle(I_CONT | I_START, CAP, "wrap_start");
        run_frame(1'b1, 1'b0, CAP);
        cmp("wrap_cnt1", 32'(frame_cnt), 32'd1);
        run_frame(1'b1, 1'b0, CAP);
        cmp("wrap_cnt2", 32'(frame_cnt), 32'd2);
        run_frame(1'b1, 1'b0, CAP);
        cmp("wrap_cnt3", 32'(frame_cnt), 32'd3);
        run_frame(1'b1, 1'b1, IDLE);
        cmp("wrap_cnt0", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
